// File: rtl/serializador_8b.sv
// Serializador de 8 bits: carrega um byte e apresenta um bit por aceite (saida_valida/saida_pronta).
// sel aponta o bit corrente e tambem comanda o mux 8:1 externo.
module serializador_8b #(
    parameter int MSB_PRIMEIRO = 0
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       inicio,
    input  logic [7:0] dado,
    input  logic       abortar,
    input  logic       saida_pronta,
    output logic [2:0] sel,
    output logic       saida,
    output logic       saida_valida,
    output logic       ocupado,
    output logic       fim
);

    typedef enum logic {OCIOSO, ENVIANDO} estado_t;

    localparam logic [2:0] SEL_PRIMEIRO = (MSB_PRIMEIRO != 0) ? 3'd7 : 3'd0;
    localparam logic [2:0] SEL_ULTIMO   = (MSB_PRIMEIRO != 0) ? 3'd0 : 3'd7;

    estado_t    estado, estado_prox;
    logic [7:0] dado_r, dado_prox;
    logic [2:0] sel_r, sel_prox;
    logic       fim_r, fim_prox;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            estado <= OCIOSO;
            dado_r <= '0;
            sel_r  <= '0;
            fim_r  <= 1'b0;
        end else begin
            estado <= estado_prox;
            dado_r <= dado_prox;
            sel_r  <= sel_prox;
            fim_r  <= fim_prox;
        end
    end

    // abortar vence o aceite do bit na mesma borda; em OCIOSO nao tem efeito
    always_comb begin
        estado_prox = estado;
        dado_prox   = dado_r;
        sel_prox    = sel_r;
        fim_prox    = 1'b0;
        case (estado)
            OCIOSO: begin
                if (inicio) begin
                    dado_prox   = dado;
                    sel_prox    = SEL_PRIMEIRO;
                    estado_prox = ENVIANDO;
                end
            end
            ENVIANDO: begin
                if (abortar) begin
                    estado_prox = OCIOSO;
                end else if (saida_pronta) begin
                    if (sel_r == SEL_ULTIMO) begin
                        estado_prox = OCIOSO;
                        fim_prox    = 1'b1;
                    end else if (MSB_PRIMEIRO != 0) begin
                        sel_prox = sel_r - 3'd1;
                    end else begin
                        sel_prox = sel_r + 3'd1;
                    end
                end
            end
            default: estado_prox = OCIOSO;
        endcase
    end

    always_comb begin
        sel          = sel_r;
        saida_valida = (estado == ENVIANDO);
        ocupado      = (estado == ENVIANDO);
        saida        = (estado == ENVIANDO) ? dado_r[sel_r] : 1'b0;
        fim          = fim_r;
    end

endmodule

// File: doc/serializador_8b.md
SERIALIZADOR_8B -- requirements
Module: serializador_8b

Interface
REQ-001 The block SHALL have parameter MSB_PRIMEIRO, default 0. 0 = bit order 0..7; 1 = bit order 7..0.
REQ-002 The block SHALL have port clock, input, 1 bit. Single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset_n, input, 1 bit. Asynchronous, active-low reset.
REQ-004 The block SHALL have port inicio, input, 1 bit. Request to load a new byte.
REQ-005 The block SHALL have port dado, input, 8 bits. Byte to serialize; sampled only when a load is accepted.
REQ-006 The block SHALL have port abortar, input, 1 bit. Synchronous abort of the transfer in progress.
REQ-007 The block SHALL have port saida_pronta, input, 1 bit. Downstream ready for the current bit.
REQ-008 The block SHALL have port sel, output, 3 bits. Index of the bit being presented; drives the downstream 8:1 mux select.
REQ-009 The block SHALL have port saida, output, 1 bit. Serial data bit = registered byte[sel].
REQ-010 The block SHALL have port saida_valida, output, 1 bit. saida and sel are valid.
REQ-011 The block SHALL have port ocupado, output, 1 bit. High while a byte is held; new loads are refused while high.
REQ-012 The block SHALL have port fim, output, 1 bit. One-cycle pulse after the last bit is accepted.

Function
REQ-013 The block SHALL implement two states: OCIOSO and ENVIANDO. ocupado = saida_valida = (state == ENVIANDO).
REQ-014 In OCIOSO, inicio=1 at a rising edge SHALL capture dado into the internal byte register, load sel with the first index (0, or 7 if MSB_PRIMEIRO=1), and enter ENVIANDO.
REQ-015 Load latency SHALL be one cycle: inicio sampled at edge k gives saida_valida=1 and the first bit on saida from edge k onward.
REQ-016 A bit SHALL be accepted at a rising edge where saida_valida=1 and saida_pronta=1.
REQ-017 On acceptance of a non-last bit, sel SHALL step by one (+1, or -1 if MSB_PRIMEIRO=1).
REQ-018 On acceptance of the last bit (index 7, or 0 if MSB_PRIMEIRO=1), the block SHALL return to OCIOSO and assert fim for exactly the next cycle.
REQ-019 While saida_valida=1 and saida_pronta=0, sel, saida and the byte register SHALL hold unchanged (stall), for any number of cycles.
REQ-020 With saida_pronta held at 1, a byte SHALL complete in exactly 8 cycles, giving 8 consecutive accepted bits.
REQ-021 inicio while in ENVIANDO SHALL be ignored. No capture occurs and the current transfer is unaffected.
REQ-022 inicio in the cycle where fim=1 SHALL be accepted (state is OCIOSO). This allows one idle cycle between back-to-back bytes.
REQ-023 In ENVIANDO, abortar=1 at an edge SHALL force OCIOSO with no fim pulse. abortar has priority over bit acceptance at that same edge.
REQ-024 abortar in OCIOSO SHALL have no effect, and a simultaneous inicio SHALL still be accepted.
REQ-025 saida SHALL be derived combinationally from the byte register and sel. It is glitch-free because both are registered.
REQ-026 In OCIOSO, saida SHALL be 0 and sel SHALL hold its last value. The downstream block must not sample sel/saida without saida_valida.
REQ-027 sel arithmetic SHALL be 3-bit. No wrap-around occurs in operation because the terminal index ends the transfer.

Reset
REQ-028 reset_n=0 SHALL immediately, without waiting for a clock edge, force: state OCIOSO; sel=3'b000; byte register=8'h00; saida=0; saida_valida=0; ocupado=0; fim=0.
REQ-029 Reset asserted mid-transfer SHALL discard the byte with no fim pulse. After release, the block SHALL accept inicio at the first rising edge.
REQ-030 Reset deassertion SHALL be sampled synchronously with clock. No state change occurs until the first edge after release.

Verification
REQ-031 MSB_PRIMEIRO=0, dado=8'hA5, inicio pulse, saida_pronta=1 -> saida sequence 1,0,1,0,0,1,0,1 with sel 0..7 over 8 cycles, then fim=1 for one cycle and ocupado=0.
REQ-032 MSB_PRIMEIRO=1, dado=8'h81, saida_pronta=1 -> sel sequence 7..0, saida 1,0,0,0,0,0,0,1, then fim pulse.
REQ-033 dado=8'h3C, saida_pronta=0 for 3 cycles while sel=2 -> sel=2 and saida=1 held for 3 cycles; total transfer 11 cycles.
REQ-034 inicio with dado=8'hFF at sel=4 during a transfer of 8'h0F -> ignored; remaining bits 0,0,0,0; then inicio with 8'hFF in the fim cycle -> accepted, 8 ones follow.
REQ-035 abortar=1 and saida_pronta=1 at sel=5 -> OCIOSO next cycle, fim stays 0, saida_valida=0.
REQ-036 reset_n pulsed low between edges at sel=3 -> outputs go to reset values before the next edge; an inicio with 8'h55 after release serializes correctly.
